// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage: execute stage of the 5-stage MIPS pipeline.
//
// Holds the single-cycle ALU, branch resolution, the operand forwarding muxes
// and an iterative signed multiply/divide unit with its HI/LO registers.
// While the mul/div unit is working, Stall_MD freezes the front of the
// pipeline and EXE/MEM captures bubbles.
//
// Build option: define FORWARDING_EN to include the Fwd_Sel1/Fwd_Sel2 operand
// muxes. Without it, operand A is Val1 and R2 is Reg2, and Fwd_Sel*,
// ALU_Res_MEM and WB_Value are ignored. That build relies on the hazard unit
// stalling instead of forwarding.
//
// Ports:
//   clk, rst            pipeline clock, asynchronous active-high reset
//   Flush               branch flush, aborts an in-flight mul/div
//   EXE_CMD[5:0]        operation code from ID/EXE
//   PC                  PC+4 of the instruction in EXE
//   Val1, Val2, Reg2    operand A, operand B/immediate, rt value
//   is_Immediate        operand B is Val2 rather than forwarded Reg2
//   Fwd_Sel1/2[1:0]     forwarding selects (0/3 ID/EXE, 1 MEM, 2 WB)
//   ALU_Res_MEM         result currently in EXE/MEM
//   WB_Value            value currently being written back
//   ALU_Result          combinational result to EXE/MEM
//   ST_Val              forwarded Reg2 (store data)
//   Br_taken, Br_Addr   branch decision and target
//   Stall_MD            mul/div stall request
// -----------------------------------------------------------------------------
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Flush,
  input  logic [5:0]       EXE_CMD,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] Val1,
  input  logic [WIDTH-1:0] Val2,
  input  logic [WIDTH-1:0] Reg2,
  input  logic             is_Immediate,
  input  logic [1:0]       Fwd_Sel1,
  input  logic [1:0]       Fwd_Sel2,
  input  logic [WIDTH-1:0] ALU_Res_MEM,
  input  logic [WIDTH-1:0] WB_Value,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] ST_Val,
  output logic             Br_taken,
  output logic [WIDTH-1:0] Br_Addr,
  output logic             Stall_MD
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] CMD_ADD  = 6'h00;
  localparam logic [5:0] CMD_SUB  = 6'h01;
  localparam logic [5:0] CMD_AND  = 6'h02;
  localparam logic [5:0] CMD_OR   = 6'h03;
  localparam logic [5:0] CMD_NOR  = 6'h04;
  localparam logic [5:0] CMD_XOR  = 6'h05;
  localparam logic [5:0] CMD_SLL  = 6'h06;
  localparam logic [5:0] CMD_SRL  = 6'h07;
  localparam logic [5:0] CMD_SRA  = 6'h08;
  localparam logic [5:0] CMD_SLT  = 6'h09;
  localparam logic [5:0] CMD_MULT = 6'h10;
  localparam logic [5:0] CMD_DIV  = 6'h11;
  localparam logic [5:0] CMD_MFHI = 6'h12;
  localparam logic [5:0] CMD_MFLO = 6'h13;
  localparam logic [5:0] CMD_BEZ  = 6'h20;
  localparam logic [5:0] CMD_BNE  = 6'h21;
  localparam logic [5:0] CMD_JMP  = 6'h22;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  md_state_t          r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;        // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic [WIDTH-1:0]   r_m;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r, r_bz;

  logic [WIDTH-1:0]   w_a, w_r2, w_b, w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_add, w_trial;
  logic [2*WIDTH-1:0] w_step, w_prod;
  logic [WIDTH-1:0]   w_fin_hi, w_fin_lo;
  logic [4:0]         w_shamt;
  logic               w_is_md, w_start, w_busy;

`ifdef FORWARDING_EN
  // forwarding muxes for operand A and the rt value
  always_comb begin
    case (Fwd_Sel1)
      2'd1:    w_a = ALU_Res_MEM;
      2'd2:    w_a = WB_Value;
      default: w_a = Val1;
    endcase
    case (Fwd_Sel2)
      2'd1:    w_r2 = ALU_Res_MEM;
      2'd2:    w_r2 = WB_Value;
      default: w_r2 = Reg2;
    endcase
  end
`else
  logic w_unused_fwd;
  assign w_a          = Val1;
  assign w_r2         = Reg2;
  assign w_unused_fwd = ^{Fwd_Sel1, Fwd_Sel2, ALU_Res_MEM, WB_Value};
`endif

  assign w_b     = is_Immediate ? Val2 : w_r2;
  assign ST_Val  = w_r2;
  assign w_shamt = w_b[4:0];
  assign w_a_mag = w_a[WIDTH-1] ? ({WIDTH{1'b0}} - w_a) : w_a;
  assign w_b_mag = w_b[WIDTH-1] ? ({WIDTH{1'b0}} - w_b) : w_b;

  assign w_is_md = (EXE_CMD == CMD_MULT) || (EXE_CMD == CMD_DIV);
  assign w_start = (r_state == S_IDLE) && w_is_md && !Flush;
  assign w_busy  = (r_state == S_BUSY);
  // MFHI/MFLO arriving during BUSY stall through w_busy; reset masks the
  // start term because the held ID/EXE contents are not yet cleared.
  assign Stall_MD = !rst && (w_start || w_busy);

  // single-cycle ALU plus HI/LO moves
  always_comb begin
    case (EXE_CMD)
      CMD_ADD:  ALU_Result = w_a + w_b;
      CMD_SUB:  ALU_Result = w_a - w_b;
      CMD_AND:  ALU_Result = w_a & w_b;
      CMD_OR:   ALU_Result = w_a | w_b;
      CMD_NOR:  ALU_Result = ~(w_a | w_b);
      CMD_XOR:  ALU_Result = w_a ^ w_b;
      CMD_SLL:  ALU_Result = w_a << w_shamt;
      CMD_SRL:  ALU_Result = w_a >> w_shamt;
      CMD_SRA:  ALU_Result = $signed(w_a) >>> w_shamt;
      CMD_SLT:  ALU_Result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      CMD_MFHI: ALU_Result = r_hi;
      CMD_MFLO: ALU_Result = r_lo;
      default:  ALU_Result = {WIDTH{1'b0}};
    endcase
  end

  // branch resolution; the target is always driven
  always_comb begin
    case (EXE_CMD)
      CMD_BEZ: Br_taken = (w_a == {WIDTH{1'b0}});
      CMD_BNE: Br_taken = (w_a != w_r2);
      CMD_JMP: Br_taken = 1'b1;
      default: Br_taken = 1'b0;
    endcase
  end
  assign Br_Addr = PC + {Val2[WIDTH-3:0], 2'b00};

  // one radix-2 iteration: shift-add multiply or restoring divide
  always_comb begin
    w_add   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    w_trial = r_p[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
    if (r_is_div) begin
      if (!w_trial[WIDTH]) begin
        w_step = {w_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
      end else begin
        w_step = {r_p[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      w_step = {w_add, r_p[WIDTH-1:1]};
    end
  end

  // sign correction of the final iteration; divide-by-zero forces LO to all ones
  always_comb begin
    w_prod = r_neg_q ? ({(2*WIDTH){1'b0}} - w_step) : w_step;
    if (r_is_div) begin
      w_fin_hi = r_neg_r ? ({WIDTH{1'b0}} - w_step[2*WIDTH-1:WIDTH]) : w_step[2*WIDTH-1:WIDTH];
      if (r_bz) begin
        w_fin_lo = {WIDTH{1'b1}};
      end else begin
        w_fin_lo = r_neg_q ? ({WIDTH{1'b0}} - w_step[WIDTH-1:0]) : w_step[WIDTH-1:0];
      end
    end else begin
      w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod[WIDTH-1:0];
    end
  end

  // mul/div state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // mul/div next state; DONE always drops to IDLE so a held MULT/DIV cannot re-trigger
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_BUSY;
        else         w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (Flush)                         w_state_nxt = S_IDLE;
        else if (r_cnt == {CW{1'b0}})      w_state_nxt = S_DONE;
        else                               w_state_nxt = S_BUSY;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // mul/div datapath, iteration counter and HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= {CW{1'b0}};
      r_p      <= {(2*WIDTH){1'b0}};
      r_m      <= {WIDTH{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
    end else if (w_start) begin
      r_is_div <= (EXE_CMD == CMD_DIV);
      r_neg_q  <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
      r_neg_r  <= w_a[WIDTH-1];
      r_bz     <= (w_b == {WIDTH{1'b0}});
      r_m      <= (EXE_CMD == CMD_DIV) ? w_b_mag : w_a_mag;
      r_p      <= {{WIDTH{1'b0}}, ((EXE_CMD == CMD_DIV) ? w_a_mag : w_b_mag)};
      r_cnt    <= CW'(WIDTH - 1);
    end else if (w_busy && !Flush) begin
      r_p <= w_step;
      if (r_cnt == {CW{1'b0}}) begin
        r_hi <= w_fin_hi;
        r_lo <= w_fin_lo;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, Flush, is_Immediate;
  logic [5:0]  EXE_CMD;
  logic [31:0] PC, Val1, Val2, Reg2, ALU_Res_MEM, WB_Value;
  logic [1:0]  Fwd_Sel1, Fwd_Sel2;
  logic [31:0] ALU_Result, ST_Val, Br_Addr;
  logic        Br_taken, Stall_MD;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Flush(Flush), .EXE_CMD(EXE_CMD), .PC(PC),
    .Val1(Val1), .Val2(Val2), .Reg2(Reg2), .is_Immediate(is_Immediate),
    .Fwd_Sel1(Fwd_Sel1), .Fwd_Sel2(Fwd_Sel2), .ALU_Res_MEM(ALU_Res_MEM),
    .WB_Value(WB_Value), .ALU_Result(ALU_Result), .ST_Val(ST_Val),
    .Br_taken(Br_taken), .Br_Addr(Br_Addr), .Stall_MD(Stall_MD)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // reference state: HI/LO, cycles left in the current mul/div (0 idle,
  // >=2 working, 1 retiring) and the results it will write
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] op_a();
`ifdef FORWARDING_EN
    if (Fwd_Sel1 == 2'd1) return ALU_Res_MEM;
    if (Fwd_Sel1 == 2'd2) return WB_Value;
`endif
    return Val1;
  endfunction

  function automatic logic [31:0] op_r2();
`ifdef FORWARDING_EN
    if (Fwd_Sel2 == 2'd1) return ALU_Res_MEM;
    if (Fwd_Sel2 == 2'd2) return WB_Value;
`endif
    return Reg2;
  endfunction

  function automatic logic [31:0] op_b();
    return is_Immediate ? Val2 : op_r2();
  endfunction

  function automatic bit is_md(input logic [5:0] c);
    return (c == 6'h10) || (c == 6'h11);
  endfunction

  function automatic logic [31:0] exp_alu();
    logic [31:0] a, b;
    int sa, sb, sh;
    a = op_a(); b = op_b(); sa = a; sb = b; sh = b % 32;
    case (EXE_CMD)
      6'h00:   return a + b;
      6'h01:   return a - b;
      6'h02:   return a & b;
      6'h03:   return a | b;
      6'h04:   return ~(a | b);
      6'h05:   return a ^ b;
      6'h06:   return a << sh;
      6'h07:   return a >> sh;
      6'h08:   return sa >>> sh;
      6'h09:   return (sa < sb) ? 32'd1 : 32'd0;
      6'h12:   return m_hi;
      6'h13:   return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_br();
    case (EXE_CMD)
      6'h20:   return op_a() == 32'd0;
      6'h21:   return op_a() != op_r2();
      6'h22:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_stall();
    if (rst) return 1'b0;
    return (m_cnt >= 2) || (m_cnt == 0 && !Flush && is_md(EXE_CMD));
  endfunction

  task automatic md_calc(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb, q, r;
    longint p;
    sa = a; sb = b;
    if (c == 6'h10) begin
      p  = longint'(sa) * longint'(sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      hi = 32'd0;
      lo = 32'h8000_0000;
    end else begin
      q = sa / sb;
      r = sa % sb;
      hi = r;
      lo = q;
    end
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (m_cnt >= 2) begin
      if (Flush) m_cnt = 0;
      else begin
        if (m_cnt == 2) begin m_hi = p_hi; m_lo = p_lo; end
        m_cnt--;
      end
    end else if (m_cnt == 1) begin
      m_cnt = 0;
    end else if (is_md(EXE_CMD) && !Flush) begin
      md_calc(EXE_CMD, op_a(), op_b(), p_hi, p_lo);
      m_cnt = 33;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  task automatic bubble();
    EXE_CMD = 6'h00; Val1 = 32'd0; Val2 = 32'd0; Reg2 = 32'd0; PC = 32'd0;
    is_Immediate = 1'b0; Fwd_Sel1 = 2'd0; Fwd_Sel2 = 2'd0; Flush = 1'b0;
    ALU_Res_MEM = 32'd0; WB_Value = 32'd0;
  endtask

  // checks every output against the reference on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("alu_result", ALU_Result, exp_alu());
      check("st_val", ST_Val, op_r2());
      check("br_taken", {31'd0, Br_taken}, {31'd0, exp_br()});
      check("br_addr", Br_Addr, PC + Val2 * 32'd4);
      check("stall_md", {31'd0, Stall_MD}, {31'd0, exp_stall()});
    end
  end

  // holds a MULT/DIV until the stall drops and returns the stall length
  task automatic run_md(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall);
    bit done;
    n_stall = 0; done = 1'b0;
    bubble();
    EXE_CMD = c; Val1 = a; Reg2 = b; Val2 = b;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (Stall_MD) begin n_stall++; cyc(); end
      else done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL md_timeout: stall still high after %0d cycles", n_stall);
    end
    cyc();
    bubble();
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
    check({nm, "_model_hi"}, m_hi, ehi);
    check({nm, "_model_lo"}, m_lo, elo);
    EXE_CMD = 6'h12;
    @(negedge clk);
    check({nm, "_mfhi"}, ALU_Result, ehi);
    cyc();
    EXE_CMD = 6'h13;
    @(negedge clk);
    check({nm, "_mflo"}, ALU_Result, elo);
    check({nm, "_mflo_stall"}, {31'd0, Stall_MD}, 32'd0);
    cyc();
    bubble();
  endtask

  function automatic logic [31:0] rv();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] cmd_pool [19] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                6'h07, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h13,
                                6'h20, 6'h21, 6'h22, 6'h0A, 6'h3F};

  initial begin
    int  ns;
    logic exp_bne;
    rst = 1'b0;
    bubble();
    model_reset();
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_alu", ALU_Result, 32'd0);
    check("rst_br", {31'd0, Br_taken}, 32'd0);
    check("rst_addr", Br_Addr, 32'd0);
    check("rst_stall", {31'd0, Stall_MD}, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    read_hilo("rst", 32'd0, 32'd0);

    // ADD with immediate
    EXE_CMD = 6'h00; Val1 = 32'd5; Val2 = 32'd7; is_Immediate = 1'b1;
    @(negedge clk);
    check("add_res", ALU_Result, 32'd12);
    check("add_br", {31'd0, Br_taken}, 32'd0);
    check("add_stall", {31'd0, Stall_MD}, 32'd0);
    cyc(); bubble();

    // MULT -1 * 3
    run_md(6'h10, 32'hFFFF_FFFF, 32'd3, ns);
    check("mult_stall_len", ns, 32'd33);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIV cases
    run_md(6'h11, 32'hFFFF_FFF9, 32'd2, ns);
    check("div_stall_len", ns, 32'd33);
    read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md(6'h11, 32'd7, 32'd0, ns);
    read_hilo("div_zero", 32'd7, 32'hFFFF_FFFF);
    run_md(6'h11, 32'h8000_0000, 32'hFFFF_FFFF, ns);
    read_hilo("div_ovf", 32'd0, 32'h8000_0000);

    // BNE with and without forwarding of rt
`ifdef FORWARDING_EN
    exp_bne = 1'b0;
`else
    exp_bne = 1'b1;
`endif
    EXE_CMD = 6'h21; Val1 = 32'd3; Reg2 = 32'd4; Fwd_Sel2 = 2'd1;
    ALU_Res_MEM = 32'd3; PC = 32'h100; Val2 = 32'd4;
    @(negedge clk);
    check("bne_fwd_taken", {31'd0, Br_taken}, {31'd0, exp_bne});
    check("bne_addr", Br_Addr, 32'h110);
    Fwd_Sel2 = 2'd0;
    @(negedge clk);
    check("bne_nofwd_taken", {31'd0, Br_taken}, 32'd1);
    cyc(); bubble();

    // reset during a MULT
    EXE_CMD = 6'h10; Val1 = 32'hFFFF_FFFF; Reg2 = 32'd3;
    repeat (10) cyc();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_mid_stall", {31'd0, Stall_MD}, 32'd0);
    bubble();
    cyc();
    rst = 1'b0;
    read_hilo("rst_mid", 32'd0, 32'd0);
    run_md(6'h10, 32'd6, 32'd7, ns);
    check("mult67_stall_len", ns, 32'd33);
    read_hilo("mult67", 32'd0, 32'd42);

    // flush in the fifth BUSY cycle of a DIV
    EXE_CMD = 6'h11; Val1 = 32'd100; Reg2 = 32'd3;
    cyc();
    repeat (4) cyc();
    Flush = 1'b1;
    cyc();
    bubble();
    @(negedge clk);
    check("flush_stall", {31'd0, Stall_MD}, 32'd0);
    read_hilo("flush", 32'd0, 32'd42);

    // randomized instruction stream
    for (int i = 0; i < 250; i++) begin
      EXE_CMD = cmd_pool[$urandom_range(0, 18)];
      if ($urandom % 10 == 0) EXE_CMD = 6'($urandom);
      Val1 = rv(); Val2 = rv(); Reg2 = rv(); ALU_Res_MEM = rv(); WB_Value = rv();
      PC = $urandom; is_Immediate = 1'($urandom);
      Fwd_Sel1 = 2'($urandom); Fwd_Sel2 = 2'($urandom);
      Flush = ($urandom % 8 == 0);
      cyc();
      Flush = 1'b0;
      for (int k = 0; k < 100 && m_cnt >= 2; k++) begin
        Flush = ($urandom % 50 == 0);
        cyc();
      end
      Flush = 1'b0;
      if (m_cnt == 1) begin
        Flush = 1'($urandom);
        cyc();
        Flush = 1'b0;
      end
    end

    bubble();
    cyc();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EXE pipeline register outputs and feeds the EXE/MEM register.
- Contains the single-cycle ALU, the branch resolution logic and operand forwarding muxes.
- Also contains an iterative signed multiply/divide unit with HI/LO registers. While that unit works, it stalls the front of the pipeline.

Parameters:
- WIDTH, 32, datapath width. Mul/div iteration count equals WIDTH.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- Flush  in  1  branch flush; aborts an in-flight mul/div
- EXE_CMD  in  6  operation code from ID/EXE register
- PC  in  32  PC+4 of the instruction in EXE
- Val1  in  32  operand A from ID/EXE
- Val2  in  32  operand B or sign-extended immediate from ID/EXE
- Reg2  in  32  rt register value (store data / branch compare)
- is_Immediate  in  1  Val2 holds an immediate; Fwd_Sel2 does not apply to operand B
- Fwd_Sel1  in  2  operand A source: 0 Val1, 1 ALU_Res_MEM, 2 WB_Value, 3 Val1
- Fwd_Sel2  in  2  Reg2/operand-B source, same encoding
- ALU_Res_MEM  in  32  result currently in EXE/MEM register
- WB_Value  in  32  value currently being written back
- ALU_Result  out  32  combinational result to EXE/MEM
- ST_Val  out  32  forwarded Reg2, used as store data
- Br_taken  out  1  branch/jump taken this cycle
- Br_Addr  out  32  branch target
- Stall_MD  out  1  freeze PC, IF/ID and ID/EXE; EXE/MEM captures a bubble

Behaviour:
- EXE_CMD encodings:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 NOR, 0x05 XOR
  - 0x06 SLL, 0x07 SRL, 0x08 SRA; shift amount is opB[4:0]
  - 0x09 SLT (signed)
  - 0x10 MULT, 0x11 DIV, 0x12 MFHI, 0x13 MFLO
  - 0x20 BEZ, 0x21 BNE, 0x22 JMP
  - any other code: ALU_Result = 0
- All-zero ID/EXE content (reset/flush bubble) executes as ADD 0+0 with no write-back. No side effects.
- Operands:
  - A = Fwd_Sel1-selected value.
  - R2 = Fwd_Sel2-selected value; ST_Val = R2.
  - B = Val2 when is_Immediate=1, else R2.
- ALU ops are combinational with zero latency. Arithmetic wraps modulo 2^WIDTH; there is no overflow trap.
- Branches (target Br_Addr = PC + (Val2<<2), always driven):
  - BEZ: Br_taken = (A==0)
  - BNE: Br_taken = (A!=R2)
  - JMP: Br_taken = 1
  - all other codes: Br_taken = 0
- MFHI/MFLO drive ALU_Result = HI/LO. If the unit is not IDLE, they stall like a new MULT/DIV, but do not restart the unit.
- Mul/div FSM states: IDLE, BUSY, DONE.
  - IDLE with EXE_CMD in {MULT, DIV} and Flush=0:
    - latch |A|, |B| and result signs; counter = WIDTH-1
    - Stall_MD=1 combinationally this cycle; go to BUSY
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide), Stall_MD=1. At counter==0, go to DONE; otherwise decrement.
  - DONE: HI/LO written with sign-corrected results on entry; Stall_MD=0. The instruction retires this cycle. Always return to IDLE next cycle, never re-trigger on the same held instruction.
  - Total: instruction occupies EXE for WIDTH+2 cycles; Stall_MD high for WIDTH+1 cycles.
- MULT results: HI:LO = 64-bit signed product.
- DIV results: LO = quotient truncated toward zero; HI = remainder with sign of dividend.
- DIV by zero: HI = dividend, LO = all ones. No exception.
- DIV of 0x80000000 by -1: LO = 0x80000000, HI = 0.
- ALU_Result for MULT/DIV is 0 and WB_EN from ID is 0; HI/LO are internal only.
- Flush=1 in BUSY: return to IDLE next edge, HI/LO unchanged, Stall_MD=0 from that edge.
- Flush=1 in IDLE or DONE: no effect on the FSM.
- Reset (any time, including mid-operation): state IDLE, counter 0, HI=LO=0, Stall_MD=0.
- Combinational outputs after reset follow the zeroed inputs: ALU_Result=0, Br_taken=0, Br_Addr=0 when PC=0.

Optional Feature:
- FORWARDING_EN
  - Defined: Fwd_Sel1/Fwd_Sel2 muxes are present, as described above.
  - Undefined: A=Val1 and R2=Reg2; Fwd_Sel*, ALU_Res_MEM and WB_Value are ignored. The hazard unit must stall instead.
  - Mul/div, branch and stall behaviour are identical in both builds.

Test Plan:
- ADD, Val1=5, Val2=7, is_Immediate=1 -> ALU_Result=12, Br_taken=0, Stall_MD=0 in the same cycle.
- MULT A=0xFFFFFFFF, B=3, held during stall -> Stall_MD high exactly 33 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFD; the following MFLO returns 0xFFFFFFFD with no stall.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV A=7, B=0 -> HI=7, LO=0xFFFFFFFF.
- BNE, Val1=3, Reg2=4, Fwd_Sel2=1, ALU_Res_MEM=3, PC=0x100, Val2=4 -> Br_taken=0, Br_Addr=0x110. Same case with Fwd_Sel2=0 -> Br_taken=1.
- rst asserted on cycle 10 of a MULT -> Stall_MD=0 immediately and HI=LO=0. Next MULT 6*7 -> LO=42 after 33 stall cycles.
- Flush in BUSY cycle 5 of a DIV -> IDLE next edge, HI/LO keep their prior values, Stall_MD=0.
